// File: rtl/abuf_load_ctrl_pkg.sv
// Shared types, constants and the burst-length helper for the accum/bias
// buffer load controller.
package abuf_load_ctrl_pkg;

  localparam int DDR_W      = 256;
  localparam int DATA_W     = 16;
  localparam int TAIL_W     = 32;
  localparam int TD_RATE    = TAIL_W / DATA_W;
  localparam int DPACK_SIZE = DDR_W / DATA_W;
  localparam int TPACK_SIZE = DDR_W / TAIL_W;

  localparam int DESC_PE_NUM = 32;
  localparam int DESC_ADDR_W = 32;
  localparam int BEATS_W     = 12;

  typedef enum logic [1:0] {
    ACC_DATA  = 2'b00,
    ACC_TAIL  = 2'b01,
    BIAS_DATA = 2'b10,
    BIAS_TAIL = 2'b11
  } trans_type_e;

  typedef struct packed {
    trans_type_e              ttype;
    logic [7:0]               num;
    logic [DESC_PE_NUM-1:0]   mask;
    logic [DESC_ADDR_W-1:0]   addr;
  } load_desc_t;

  // DDR beats the loader consumes for num+1 entries of the given kind.
  function automatic logic [BEATS_W-1:0] beats(input trans_type_e t, input logic [7:0] num);
    logic [BEATS_W-1:0] n;
    n = BEATS_W'(num) + BEATS_W'(1);
    case (t)
      ACC_DATA:  beats = n;
      ACC_TAIL:  beats = n * BEATS_W'(TD_RATE);
      BIAS_DATA: beats = (n + BEATS_W'(DPACK_SIZE - 1)) / BEATS_W'(DPACK_SIZE);
      BIAS_TAIL: beats = (n + BEATS_W'(TPACK_SIZE - 1)) / BEATS_W'(TPACK_SIZE);
      default:   beats = '0;
    endcase
  endfunction

endpackage

// File: rtl/abuf_load_ctrl_fifo.sv
// Small synchronous FIFO holding pending load descriptors.
module load_desc_fifo
  import abuf_load_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  load_desc_t data_i,
  input  logic       pop_i,
  output load_desc_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  load_desc_t     mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit tells a full queue apart from an empty one.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/abuf_load_ctrl.sv
// Sequences DDR->accum/bias buffer loads: per queued descriptor it starts the
// loader, issues one read burst, waits for the loader to finish, then retires.
module abuf_load_ctrl
  import abuf_load_ctrl_pkg::*;
#(
  parameter int PE_NUM     = DESC_PE_NUM,
  parameter int DESC_DEPTH = 4,
  parameter int DDR_ADDR_W = DESC_ADDR_W,
  parameter int LEN_W      = BEATS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [7:0]            cmd_num,
  input  logic [PE_NUM-1:0]     cmd_mask,
  input  logic [DDR_ADDR_W-1:0] cmd_addr,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [DDR_ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]      rd_req_len,
  output logic                  ld_start,
  input  logic                  ld_done,
  output logic [1:0]            ld_trans_type,
  output logic [7:0]            ld_trans_num,
  output logic [PE_NUM-1:0]     ld_mask,
  output logic                  busy,
  output logic [15:0]           retired_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_REQ, S_WAIT} state_e;

  state_e                state_q;
  logic                  ld_start_q;
  logic                  rd_req_valid_q;
  logic [DDR_ADDR_W-1:0] rd_req_addr_q;
  logic [LEN_W-1:0]      rd_req_len_q;
  logic [1:0]            ld_trans_type_q;
  logic [7:0]            ld_trans_num_q;
  logic [PE_NUM-1:0]     ld_mask_q;
  logic                  armed_q;
  logic [15:0]           retired_cnt_q;

  load_desc_t push_desc;
  load_desc_t head_desc;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign push_desc = '{ttype: trans_type_e'(cmd_type), num: cmd_num, mask: cmd_mask, addr: cmd_addr};
  assign pop       = (state_q == S_IDLE) && !fifo_empty;

  load_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (cmd_valid),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Loader config stays on the outputs until the next descriptor's start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ld_start_q      <= 1'b0;
      rd_req_valid_q  <= 1'b0;
      rd_req_addr_q   <= '0;
      rd_req_len_q    <= '0;
      ld_trans_type_q <= '0;
      ld_trans_num_q  <= '0;
      ld_mask_q       <= '0;
      armed_q         <= 1'b0;
      retired_cnt_q   <= '0;
    end else begin
      ld_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            ld_trans_type_q <= head_desc.ttype;
            ld_trans_num_q  <= head_desc.num;
            ld_mask_q       <= head_desc.mask;
            rd_req_addr_q   <= head_desc.addr;
            rd_req_len_q    <= LEN_W'(beats(head_desc.ttype, head_desc.num));
            ld_start_q      <= 1'b1;
            state_q         <= S_START;
          end
        end
        S_START: begin
          rd_req_valid_q <= 1'b1;
          state_q        <= S_REQ;
        end
        S_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid_q <= 1'b0;
            armed_q        <= 1'b0;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ld_done idles high, so only a low->high transition means finished.
          if (!ld_done) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            retired_cnt_q <= retired_cnt_q + 16'd1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = !fifo_full;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;
  assign ld_start      = ld_start_q;
  assign rd_req_valid  = rd_req_valid_q;
  assign rd_req_addr   = rd_req_addr_q;
  assign rd_req_len    = rd_req_len_q;
  assign ld_trans_type = ld_trans_type_q;
  assign ld_trans_num  = ld_trans_num_q;
  assign ld_mask       = ld_mask_q;
  assign retired_cnt   = retired_cnt_q;

endmodule

// File: tb/tb_abuf_load_ctrl.sv
// Randomized bench for abuf_load_ctrl against a descriptor-queue reference
// model, with a behavioural loader and DDR responder.
module tb_abuf_load_ctrl;

  localparam int TD    = 2;
  localparam int DP    = 16;
  localparam int TP    = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [7:0]  cmd_num;
  logic [31:0] cmd_mask;
  logic [31:0] cmd_addr;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [11:0] rd_req_len;
  logic        ld_start;
  logic        ld_done;
  logic [1:0]  ld_trans_type;
  logic [7:0]  ld_trans_num;
  logic [31:0] ld_mask;
  logic        busy;
  logic [15:0] retired_cnt;

  abuf_load_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_num       (cmd_num),
    .cmd_mask      (cmd_mask),
    .cmd_addr      (cmd_addr),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_req_len    (rd_req_len),
    .ld_start      (ld_start),
    .ld_done       (ld_done),
    .ld_trans_type (ld_trans_type),
    .ld_trans_num  (ld_trans_num),
    .ld_mask       (ld_mask),
    .busy          (busy),
    .retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  n;
    logic [31:0] m;
    logic [31:0] a;
  } desc_s;

  int    vectors;
  int    miscompares;
  desc_s stimQ[$];
  desc_s modelQ[$];
  desc_s cur;
  bit    curValid, active, hsDone, burst, finalPhase, doneReset;
  int    sinceStart, hiDelay, lowHold, postHsLow, retiredExp, stallLeft;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int expBeats(input desc_s d);
    int n;
    n = int'(d.n) + 1;
    case (d.t)
      2'd0:    return n;
      2'd1:    return n * TD;
      2'd2:    return (n + DP - 1) / DP;
      default: return (n + TP - 1) / TP;
    endcase
  endfunction

  function automatic desc_s mkDesc(input logic [1:0] t, input logic [7:0] n, input logic [31:0] a);
    desc_s d;
    d.t = t;
    d.n = n;
    d.m = $urandom;
    d.a = a;
    return d;
  endfunction

  function automatic desc_s randDesc();
    desc_s d;
    int    sel;
    d.t = 2'($urandom_range(0, 3));
    sel = int'($urandom_range(0, 7));
    d.n = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
    sel = int'($urandom_range(0, 7));
    d.m = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
    d.a = $urandom;
    return d;
  endfunction

  // One clock: check outputs after the last edge, then drive the next edge.
  task automatic applyStimulus();
    bit expValid;
    @(negedge clk);
    if (ld_start) begin
      checkOutput("start_while_active", 64'(active), 64'd0);
      checkOutput("start_with_empty_queue", 64'(modelQ.size() == 0), 64'd0);
      if (modelQ.size() > 0) begin
        cur        = modelQ.pop_front();
        curValid   = 1'b1;
        active     = 1'b1;
        hsDone     = 1'b0;
        sinceStart = 0;
        hiDelay    = int'($urandom_range(0, 3));
        lowHold    = int'($urandom_range(1, 6));
        postHsLow  = 0;
      end
    end
    if (curValid) begin
      checkOutput("ld_trans_type", 64'(ld_trans_type), 64'(cur.t));
      checkOutput("ld_trans_num", 64'(ld_trans_num), 64'(cur.n));
      checkOutput("ld_mask", 64'(ld_mask), 64'(cur.m));
    end else begin
      checkOutput("ld_cfg_idle_zero", {ld_trans_type, ld_trans_num, ld_mask}, 64'd0);
    end
    expValid = active && !hsDone && (sinceStart >= 1);
    checkOutput("rd_req_valid", 64'(rd_req_valid), 64'(expValid));
    if (expValid) begin
      checkOutput("rd_req_addr", 64'(rd_req_addr), 64'(cur.a));
      checkOutput("rd_req_len", 64'(rd_req_len), 64'(expBeats(cur)));
    end
    checkOutput("retired_cnt", 64'(retired_cnt), 64'(16'(retiredExp)));
    checkOutput("cmd_ready", 64'(cmd_ready), 64'(modelQ.size() < DEPTH));
    checkOutput("busy", 64'(busy), 64'(active || (modelQ.size() > 0)));

    if (finalPhase && !doneReset && active && hsDone && modelQ.size() >= 2) begin
      rst          = 1'b1;
      cmd_valid    = 1'b0;
      ld_done      = 1'b1;
      rd_req_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_ld_start", 64'(ld_start), 64'd0);
      checkOutput("rst_rd_req", {rd_req_valid, rd_req_addr, rd_req_len}, 64'd0);
      checkOutput("rst_ld_cfg", {ld_trans_type, ld_trans_num, ld_mask}, 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_retired_cnt", 64'(retired_cnt), 64'd0);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      rst = 1'b0;
      modelQ.delete();
      active     = 1'b0;
      curValid   = 1'b0;
      hsDone     = 1'b0;
      retiredExp = 0;
      doneReset  = 1'b1;
      return;
    end

    // Loader: done idles high, drops after a short delay, and rises again
    // only once the burst was accepted and some data time has passed.
    if (active) begin
      if (hsDone && postHsLow >= lowHold) begin
        ld_done = 1'b1;
        retiredExp++;
        active = 1'b0;
      end else if (sinceStart >= hiDelay) begin
        ld_done = 1'b0;
        if (hsDone) postHsLow++;
      end else begin
        ld_done = 1'b1;
      end
      sinceStart++;
    end else begin
      ld_done = 1'b1;
    end

    if (stallLeft > 0) begin
      rd_req_ready = 1'b0;
      stallLeft--;
    end else if ($urandom_range(0, 29) == 0) begin
      rd_req_ready = 1'b0;
      stallLeft    = 20;
    end else begin
      rd_req_ready = ($urandom_range(0, 2) != 0);
    end
    if (active && !hsDone && rd_req_valid && rd_req_ready) hsDone = 1'b1;

    if ($urandom_range(0, 19) == 0) burst = !burst;
    if (stimQ.size() > 0 && (finalPhase || burst || $urandom_range(0, 3) == 0)) begin
      cmd_valid = 1'b1;
      cmd_type  = stimQ[0].t;
      cmd_num   = stimQ[0].n;
      cmd_mask  = stimQ[0].m;
      cmd_addr  = stimQ[0].a;
      if (cmd_ready) modelQ.push_back(stimQ.pop_front());
    end else begin
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom);
      cmd_num   = 8'($urandom);
      cmd_mask  = $urandom;
      cmd_addr  = $urandom;
    end
  endtask

  task automatic runUntilIdle(input int cap, input string tag);
    int cyc;
    cyc = 0;
    while ((stimQ.size() > 0 || modelQ.size() > 0 || active) && cyc < cap) begin
      applyStimulus();
      cyc++;
    end
    checkOutput(tag, 64'(cyc < cap), 64'd1);
  endtask

  initial begin
    int cyc;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_type     = '0;
    cmd_num      = '0;
    cmd_mask     = '0;
    cmd_addr     = '0;
    rd_req_ready = 1'b0;
    ld_done      = 1'b1;
    curValid     = 1'b0;
    active       = 1'b0;
    hsDone       = 1'b0;
    burst        = 1'b1;
    finalPhase   = 1'b0;
    doneReset    = 1'b0;
    retiredExp   = 0;
    stallLeft    = 0;
    sinceStart   = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ld_start", 64'(ld_start), 64'd0);
    checkOutput("reset_rd_req", {rd_req_valid, rd_req_addr, rd_req_len}, 64'd0);
    checkOutput("reset_ld_cfg", {ld_trans_type, ld_trans_num, ld_mask}, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_retired_cnt", 64'(retired_cnt), 64'd0);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    stimQ.push_back(mkDesc(2'd0, 8'd9, 32'h0000_1000));
    stimQ.push_back(mkDesc(2'd1, 8'd3, 32'h0000_2000));
    stimQ.push_back(mkDesc(2'd2, 8'd16, 32'h0000_3000));
    stimQ.push_back(mkDesc(2'd3, 8'd7, 32'h0000_4000));
    for (int i = 0; i < 60; i++) stimQ.push_back(randDesc());
    runUntilIdle(20000, "drain_timeout_random");

    finalPhase = 1'b1;
    for (int i = 0; i < 3; i++) stimQ.push_back(randDesc());
    cyc = 0;
    while (!doneReset && cyc < 2000) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("reset_in_wait_reached", 64'(doneReset), 64'd1);
    stimQ.delete();

    for (int i = 0; i < 2; i++) stimQ.push_back(randDesc());
    runUntilIdle(2000, "drain_timeout_after_reset");
    repeat (2) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
